// File: rtl/imem_loader.sv
// Framed byte-stream loader feeding the instruction memory write port.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  InData,
  input  logic        InValid,
  output logic        InReady,
  output logic [31:0] WriteData,
  output logic [31:0] WriteAddr,
  output logic [1:0]  WIM,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, TAIL, CHK, DONE} state_t;

  state_t      state_q, state_d, post_state;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [15:0] start_q, start_d, len_q, len_d, cnt_q, cnt_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic        reject_q, reject_d;
  logic        in_ready_q, in_ready_d, post_ready;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] waddr_q, waddr_d;
  logic [1:0]  wim_q, wim_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        accept, last;
  logic [15:0] base, len_full;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign InReady   = in_ready_q;
  assign WriteData = wdata_q;
  assign WriteAddr = {16'h0000, waddr_q};
  assign WIM       = wim_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = error_q;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    start_d    = start_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    reject_d   = reject_q;
    in_ready_d = in_ready_q;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    wr_data    = 32'h0000_0000;
    wr_size    = 2'd0;
    accept     = InValid && in_ready_q;
    last       = (cnt_q == (len_q - 16'd1));
    base       = start_q + {cnt_q[15:2], 2'b00};
    len_full   = {InData, len_q[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    post_state = CHK;
    post_ready = 1'b1;
`else
    post_state = DONE;
    post_ready = 1'b0;
`endif
    // Done/Error trail the DONE state by one cycle so they follow the final write.
    done_d  = (state_q == DONE);
    error_d = (state_q == DONE) && reject_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          start_d[7:0] = InData;
          hcnt_d       = 2'd1;
          state_d      = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          hcnt_d = hcnt_q + 2'd1;
          case (hcnt_q)
            2'd1: start_d[15:8] = InData;
            2'd2: len_d[7:0]    = InData;
            default: begin
              len_d[15:8] = InData;
              reject_d    = ({1'b0, start_q} + {1'b0, len_full}) > 17'h10000;
              cnt_d       = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum_d      = 8'h00;
`endif
              if (len_full == 16'd0) begin
                state_d    = post_state;
                in_ready_d = post_ready;
              end else begin
                state_d    = DATA;
              end
            end
          endcase
        end
      end
      DATA: begin
        if (accept) begin
          cnt_d = cnt_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ InData;
`endif
          case (cnt_q[1:0])
            2'd0:    b0_d = InData;
            2'd1:    b1_d = InData;
            2'd2:    b2_d = InData;
            default: b0_d = b0_q;
          endcase
          if (cnt_q[1:0] == 2'd3) begin
            wr_data = {InData, b2_q, b1_q, b0_q};
            wr_size = 2'd3;
          end else if (last) begin
            case (cnt_q[1:0])
              2'd0: begin
                wr_data = {24'h000000, InData};
                wr_size = 2'd1;
              end
              2'd1: begin
                wr_data = {16'h0000, InData, b0_q};
                wr_size = 2'd2;
              end
              default: begin
                wr_data = {16'h0000, b1_q, b0_q};
                wr_size = 2'd2;
              end
            endcase
          end else begin
            wr_size = 2'd0;
          end
          if (last) begin
            if (cnt_q[1:0] == 2'd2) begin
              state_d    = TAIL;
              in_ready_d = 1'b0;
            end else begin
              state_d    = post_state;
              in_ready_d = post_ready;
            end
          end
        end
      end
      TAIL: begin
        // cnt_q already points past the last byte but still shares its word base.
        wr_data    = {24'h000000, b2_q};
        wr_size    = 2'd1;
        base       = base + 16'd2;
        state_d    = post_state;
        in_ready_d = 1'b0;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready_d = 1'b1;
        if (accept) begin
          reject_d   = reject_q | (InData != csum_q);
          state_d    = DONE;
          in_ready_d = 1'b0;
        end
      end
`endif
      DONE: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
      end
    endcase

    if ((wr_size != 2'd0) && !reject_q) begin
      wim_d   = wr_size;
      wdata_d = wr_data;
      waddr_d = base;
    end else begin
      wim_d   = 2'd0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      hcnt_q     <= 2'd0;
      start_q    <= 16'h0000;
      len_q      <= 16'h0000;
      cnt_q      <= 16'h0000;
      b0_q       <= 8'h00;
      b1_q       <= 8'h00;
      b2_q       <= 8'h00;
      reject_q   <= 1'b0;
      in_ready_q <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      waddr_q    <= 16'h0000;
      wim_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      start_q    <= start_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      reject_q   <= reject_d;
      in_ready_q <= in_ready_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      wim_q      <= wim_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames
// compared against a frame-level model of the expected memory writes.
module tb_imem_loader;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  InData;
  logic        InValid;
  logic        InReady;
  logic [31:0] WriteData;
  logic [31:0] WriteAddr;
  logic [1:0]  WIM;
  logic        Busy;
  logic        Done;
  logic        Error;

  imem_loader dut (
    .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(InReady),
    .WriteData(WriteData), .WriteAddr(WriteAddr), .WIM(WIM),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  wim;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    bit          chk_rdy;
    int          c;
  } wr_t;

  int   cyc = 0;
  wr_t  got[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_err = 1'b0;
  int   stray = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_acc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Output monitor: records every write and Done/Error pulse
  always @(negedge Clk) begin
    if (!Rst) begin
      if (WIM != 2'd0) got.push_back('{WIM, WriteAddr, WriteData, InReady, 1'b0, cyc});
      if (Done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        done_err <= Error;
      end
      if (Error && !Done) stray <= stray + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit r;
    int guard;
    int acc_c;
    @(negedge Clk);
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      InValid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge Clk);
    end
    InData  = b;
    InValid = 1'b1;
    guard   = 0;
    forever begin
      acc_c = cyc + 1;
      r     = InReady;
      @(posedge Clk);
      if (r) begin
        last_acc = acc_c;
        break;
      end
      guard++;
      if (guard > 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_byte timeout observed=InReady low expected=accept");
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] start, input logic [7:0] pl[$],
                           input bit gaps, input bit bad_csum);
    wr_t  exp[$];
    logic [15:0] len;
    logic [7:0]  x;
    bit   ok_range, exp_err;
    int   d0, guard, full, rem, off;
    logic [31:0] base;
    len      = 16'(pl.size());
    ok_range = ({1'b0, start} + {1'b0, len}) <= 17'h10000;
    x        = 8'h00;
    foreach (pl[i]) x = x ^ pl[i];
    // Reference: whole words first, then the remainder as byte/halfword pieces
    full = int'(len) / 4;
    rem  = int'(len) % 4;
    if (ok_range) begin
      for (int w = 0; w < full; w++)
        exp.push_back('{2'd3, 32'(start) + 32'(4 * w),
                        {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]}, 1'b0, 1'b0, 0});
      base = 32'(start) + 32'(4 * full);
      if (rem == 1) exp.push_back('{2'd1, base, {24'h0, pl[4*full]}, 1'b0, 1'b0, 0});
      if (rem >= 2) exp.push_back('{2'd2, base, {16'h0, pl[4*full+1], pl[4*full]}, 1'b0, 1'b0, 0});
      if (rem == 3) exp.push_back('{2'd1, base + 32'd2, {24'h0, pl[4*full+2]}, 1'b0, 1'b1, 0});
    end
    exp_err = !ok_range;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = exp_err || bad_csum;
    off     = 1;
`else
    off     = (rem == 3) ? 2 : 1;
`endif

    @(negedge Clk);
    #1;
    got.delete();
    d0 = done_cnt;
    send_byte(start[7:0], gaps);
    send_byte(start[15:8], gaps);
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    foreach (pl[i]) send_byte(pl[i], gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x ^ (bad_csum ? 8'h01 : 8'h00), gaps);
`endif
    @(negedge Clk);
    InValid = 1'b0;
    #1;
    guard = 0;
    while ((done_cnt == d0) && (guard < 20)) begin
      @(negedge Clk);
      #1;
      guard++;
    end
    repeat (3) @(negedge Clk);
    #1;
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_error"}, {31'd0, done_err}, {31'd0, exp_err});
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(last_acc + off));
    check({tag, "_nwrites"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s_wim%0d", tag, i), {30'd0, got[i].wim}, {30'd0, exp[i].wim});
      check($sformatf("%s_addr%0d", tag, i), got[i].addr, exp[i].addr);
      check($sformatf("%s_data%0d", tag, i), got[i].data, exp[i].data);
      if (exp[i].chk_rdy) check($sformatf("%s_tailrdy%0d", tag, i), {31'd0, got[i].rdy}, 32'd0);
      if (!gaps && i > 0 && exp[i].wim == 2'd3)
        check($sformatf("%s_spacing%0d", tag, i), 32'(got[i].c - got[i-1].c), 32'd4);
    end
  endtask

  initial begin
    logic [7:0]  pl[$];
    logic [15:0] st;
    int          n;
    Rst     = 1'b1;
    InValid = 1'b0;
    InData  = 8'h00;
    repeat (3) @(negedge Clk);
    check("reset_data", WriteData | WriteAddr, 32'd0);
    check("reset_ctl", {27'd0, WIM, Done, Error, Busy, InReady}, 32'd0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check("idle_ready", {31'd0, InReady}, 32'd1);

    pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame("t_words", 16'h1000, pl, 1'b0, 1'b0);
    pl = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    run_frame("t_tail", 16'h0020, pl, 1'b0, 1'b0);
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    run_frame("t_reject", 16'hFFFE, pl, 1'b0, 1'b0);
    run_frame("t_top", 16'hFFFC, pl, 1'b0, 1'b0);
    pl = {};
    run_frame("t_len0", 16'h0300, pl, 1'b0, 1'b0);
    pl = {8'h5A};
    run_frame("t_one", 16'h0401, pl, 1'b0, 1'b0);
    pl = {8'h5A, 8'hC3};
    run_frame("t_two", 16'h0402, pl, 1'b0, 1'b0);

    // Reset in the middle of a payload
    @(negedge Clk);
    #1;
    got.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge Clk);
    InValid = 1'b0;
    check("mid_busy", {31'd0, Busy}, 32'd1);
    #2 Rst = 1'b1;
    #1;
    check("mid_rst_data", WriteData | WriteAddr, 32'd0);
    check("mid_rst_ctl", {27'd0, WIM, Done, Error, Busy, InReady}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    check("mid_no_write", 32'(got.size()), 32'd0);
    pl = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
    run_frame("t_after_rst", 16'h0100, pl, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    run_frame("t_csum_ok", 16'h0200, pl, 1'b0, 1'b0);
    run_frame("t_csum_bad", 16'h0200, pl, 1'b0, 1'b1);
`endif

    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(0, 2) == 0) st = 16'hFFFF - 16'($urandom_range(0, 12));
      else st = 16'($urandom);
      n  = $urandom_range(0, 13);
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f), st, pl, 1'b1, bit'($urandom_range(0, 1)));
    end

    check("busy_idle", {31'd0, Busy}, 32'd0);
    check("stray_error", 32'(stray), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
